uart_regs: RTL and testbench

- Memory-mapped UART peripheral directly downstream of the IO/RAM address decoder.
- Consumes the decoder's UART write strobe and register-select code, and returns read data to the load mux when the decoder selects the UART path.
- Holds the CTRL, STAT, BAUD, TDR and RDR registers, and contains an 8N1 transmitter and receiver clocked by a programmable bit-period divider.

---
 rtl/uart_regs_pkg.sv | 48 ++++
 rtl/uart_bit_timer.sv | 38 +++
 rtl/uart_regs.sv | 247 ++++++++++++++++++++++++
 tb/tb_uart_regs.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_regs_pkg.sv
// uart_regs_pkg
// Shared definitions for the memory-mapped UART: register-select codes used
// by the IO/RAM decoder, CTRL/STAT bit positions, the UART address map, the
// serial FSM state type and the BAUD clamp helper.
package uart_regs_pkg;

    // Register-select codes (write select and read select share them).
    localparam logic [2:0] UART_MUX_CTRL = 3'd0;
    localparam logic [2:0] UART_MUX_STAT = 3'd1;
    localparam logic [2:0] UART_MUX_BAUD = 3'd2;
    localparam logic [2:0] UART_MUX_TDR  = 3'd3;
    localparam logic [2:0] UART_MUX_RDR  = 3'd4;

    // CTRL[3:0] = {RXIE, TXIE, RE, TE}
    localparam int CTRL_TE   = 0;
    localparam int CTRL_RE   = 1;
    localparam int CTRL_TXIE = 2;
    localparam int CTRL_RXIE = 3;

    // STAT[4:0] = {FE, ORE, RXNE, TC, TXE}
    localparam int STAT_TXE  = 0;
    localparam int STAT_TC   = 1;
    localparam int STAT_RXNE = 2;
    localparam int STAT_ORE  = 3;
    localparam int STAT_FE   = 4;

    // UART window in the IO region, one word per register.
    localparam logic [31:0] UART_BASE_ADDR = 32'h0000_F000;
    localparam logic [31:0] UART_CTRL_ADDR = UART_BASE_ADDR + 32'h00;
    localparam logic [31:0] UART_STAT_ADDR = UART_BASE_ADDR + 32'h04;
    localparam logic [31:0] UART_BAUD_ADDR = UART_BASE_ADDR + 32'h08;
    localparam logic [31:0] UART_TDR_ADDR  = UART_BASE_ADDR + 32'h0C;
    localparam logic [31:0] UART_RDR_ADDR  = UART_BASE_ADDR + 32'h10;

    // State type shared by the TX and RX frame FSMs.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // A bit period shorter than lo cannot be timed, so raise it to lo.
    function automatic logic [15:0] clamp_baud(input logic [15:0] v, input logic [15:0] lo);
        return (v < lo) ? lo : v;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer
// Bit-period down-counter. tick is high in the last clock of each period.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          restart the period this edge (loads period, or period>>1)
//   half           on start, time a half period (RX start-bit centring)
//   period[15:0]   clocks per bit; re-read at every reload, so a new value
//                  only takes effect at a period boundary
//   tick           period elapsed (counter at zero)
module uart_bit_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        half,
    input  logic [15:0] period,
    output logic        tick
);
    logic [15:0] cnt;
    logic [15:0] reload;

    assign reload = half ? {1'b0, period[15:1]} : period;
    assign tick   = (cnt == 16'd0);

    // Free-running once started: after the first (possibly half) period it
    // keeps reloading full periods, which gives the FSMs evenly spaced ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 16'd0;
        end else if (start) begin
            cnt <= reload - 16'd1;
        end else if (cnt == 16'd0) begin
            cnt <= period - 16'd1;
        end else begin
            cnt <= cnt - 16'd1;
        end
    end

endmodule

// File: rtl/uart_regs.sv
// uart_regs
// Memory-mapped 8N1 UART: CTRL/STAT/BAUD/TDR/RDR registers plus TX and RX
// frame FSMs, each timed by its own uart_bit_timer.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   we_uart               decoder write strobe, one cycle per store
//   uart_reg_mux_out[2:0] write register select
//   rd_sel[2:0]           read register select (rdata is combinational)
//   rd_en                 load in progress; with rd_sel=RDR it consumes RXNE
//   wdata[31:0]           store data
//   rdata[31:0]           read data, zero-extended, unused codes read 0
//   rx                    asynchronous serial input
//   tx                    serial output, idle high
//   irq                   (TXIE & TXE) | (RXIE & RXNE)
// Bus handshake: there is no back-pressure. A write takes effect on the edge
// that samples we_uart=1; a read is a pure combinational select, and only
// the RDR read with rd_en=1 has a side effect, on the following edge.
module uart_regs
    import uart_regs_pkg::*;
#(
    parameter logic [15:0] BAUD_DEFAULT = 16'd434,
    parameter logic [15:0] BAUD_MIN     = 16'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_uart,
    input  logic [2:0]  uart_reg_mux_out,
    input  logic [2:0]  rd_sel,
    input  logic        rd_en,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        rx,
    output logic        tx,
    output logic        irq
);
    // Register state
    logic [3:0]  ctrl;
    logic        txe, tc, rxne, ore, fe;
    logic [15:0] baud;
    logic [7:0]  tdr, rdr;

    // Frame FSM state
    uart_state_e tx_state, tx_state_d, rx_state, rx_state_d;
    logic [2:0]  tx_bit, rx_bit;
    logic [7:0]  tx_sh, rx_sh;
    logic        rx_meta, rx_sync, rx_prev;

    // Strobes between decode, FSMs and flags
    logic wr_ctrl, wr_stat, wr_baud, wr_tdr, rd_rdr, tdr_wr_ok;
    logic tx_can_start, tx_load, tx_shift, tx_done, tx_tstart, tx_tick;
    logic rx_fall, rx_tstart, rx_sample, rx_set_rxne, rx_set_ore, rx_set_fe, rx_tick;
    logic [7:0] tx_start_data;
    logic unused_wdata_hi;

    assign unused_wdata_hi = ^wdata[31:16];

    assign wr_ctrl   = we_uart && (uart_reg_mux_out == UART_MUX_CTRL);
    assign wr_stat   = we_uart && (uart_reg_mux_out == UART_MUX_STAT);
    assign wr_baud   = we_uart && (uart_reg_mux_out == UART_MUX_BAUD);
    assign wr_tdr    = we_uart && (uart_reg_mux_out == UART_MUX_TDR);
    assign rd_rdr    = rd_en && (rd_sel == UART_MUX_RDR);
    assign tdr_wr_ok = wr_tdr && txe;

    // A write accepted into an empty TDR may be unloaded on the same edge,
    // so the start bit appears the cycle after the write and TXE stays 1.
    assign tx_can_start  = ctrl[CTRL_TE] && (!txe || tdr_wr_ok);
    assign tx_start_data = txe ? wdata[7:0] : tdr;

    uart_bit_timer u_tx_timer (
        .clk(clk), .rst_n(rst_n), .start(tx_tstart), .half(1'b0),
        .period(baud), .tick(tx_tick)
    );

    uart_bit_timer u_rx_timer (
        .clk(clk), .rst_n(rst_n), .start(rx_tstart), .half(1'b1),
        .period(baud), .tick(rx_tick)
    );

    // TX next-state
    always_comb begin
        tx_state_d = tx_state;
        tx_load    = 1'b0;
        tx_shift   = 1'b0;
        tx_done    = 1'b0;
        tx_tstart  = 1'b0;
        case (tx_state)
            ST_IDLE: if (tx_can_start) begin
                tx_state_d = ST_START;
                tx_load    = 1'b1;
                tx_tstart  = 1'b1;
            end
            ST_START: if (tx_tick) tx_state_d = ST_DATA;
            ST_DATA: if (tx_tick) begin
                tx_shift = 1'b1;
                if (tx_bit == 3'd7) tx_state_d = ST_STOP;
            end
            ST_STOP: if (tx_tick) begin
                if (tx_can_start) begin
                    tx_state_d = ST_START;
                    tx_load    = 1'b1;
                    tx_tstart  = 1'b1;
                end else begin
                    tx_state_d = ST_IDLE;
                    tx_done    = 1'b1;
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
    end

    // Decoded from state so reset drives tx high without waiting for a clock.
    always_comb begin
        tx = 1'b1;
        if (tx_state == ST_START)     tx = 1'b0;
        else if (tx_state == ST_DATA) tx = tx_sh[0];
    end

    // RX next-state
    assign rx_fall = rx_prev && !rx_sync;

    always_comb begin
        rx_state_d  = rx_state;
        rx_tstart   = 1'b0;
        rx_sample   = 1'b0;
        rx_set_rxne = 1'b0;
        rx_set_ore  = 1'b0;
        rx_set_fe   = 1'b0;
        case (rx_state)
            ST_IDLE: if (ctrl[CTRL_RE] && rx_fall) begin
                rx_state_d = ST_START;
                rx_tstart  = 1'b1;
            end
            // Mid-start-bit check: a line already back high was a glitch.
            ST_START: if (rx_tick) rx_state_d = rx_sync ? ST_IDLE : ST_DATA;
            ST_DATA: if (rx_tick) begin
                rx_sample = 1'b1;
                if (rx_bit == 3'd7) rx_state_d = ST_STOP;
            end
            ST_STOP: if (rx_tick) begin
                rx_state_d = ST_IDLE;
                if (!rx_sync)  rx_set_fe   = 1'b1;
                else if (rxne) rx_set_ore  = 1'b1;
                else           rx_set_rxne = 1'b1;
            end
            default: rx_state_d = ST_IDLE;
        endcase
        // Dropping RE abandons the frame without touching any flag.
        if (!ctrl[CTRL_RE]) begin
            rx_state_d  = ST_IDLE;
            rx_tstart   = 1'b0;
            rx_sample   = 1'b0;
            rx_set_rxne = 1'b0;
            rx_set_ore  = 1'b0;
            rx_set_fe   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= ST_IDLE;
            rx_state <= ST_IDLE;
        end else begin
            tx_state <= tx_state_d;
            rx_state <= rx_state_d;
        end
    end

    // Datapath and register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl    <= 4'd0;
            txe     <= 1'b1;
            tc      <= 1'b1;
            rxne    <= 1'b0;
            ore     <= 1'b0;
            fe      <= 1'b0;
            baud    <= BAUD_DEFAULT;
            tdr     <= 8'd0;
            rdr     <= 8'd0;
            tx_bit  <= 3'd0;
            tx_sh   <= 8'd0;
            rx_bit  <= 3'd0;
            rx_sh   <= 8'd0;
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;

            if (wr_ctrl) ctrl <= wdata[3:0];
            if (wr_baud) baud <= clamp_baud(wdata[15:0], BAUD_MIN);
            if (tdr_wr_ok) tdr <= wdata[7:0];

            if (tx_load)        txe <= 1'b1;
            else if (tdr_wr_ok) txe <= 1'b0;

            if (tx_load)      tc <= 1'b0;
            else if (tx_done) tc <= 1'b1;

            if (tx_load) begin
                tx_sh  <= tx_start_data;
                tx_bit <= 3'd0;
            end else if (tx_shift) begin
                tx_sh  <= {1'b0, tx_sh[7:1]};
                tx_bit <= tx_bit + 3'd1;
            end

            if (rx_tstart) begin
                rx_bit <= 3'd0;
            end else if (rx_sample) begin
                rx_sh  <= {rx_sync, rx_sh[7:1]};
                rx_bit <= rx_bit + 3'd1;
            end

            // Hardware set has priority over software clear.
            if (rx_set_rxne) begin
                rdr  <= rx_sh;
                rxne <= 1'b1;
            end else if (rd_rdr) begin
                rxne <= 1'b0;
            end

            if (rx_set_ore)                      ore <= 1'b1;
            else if (wr_stat && wdata[STAT_ORE]) ore <= 1'b0;

            if (rx_set_fe)                       fe <= 1'b1;
            else if (wr_stat && wdata[STAT_FE])  fe <= 1'b0;
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (rd_sel)
            UART_MUX_CTRL: rdata = {28'd0, ctrl};
            UART_MUX_STAT: rdata = {27'd0, fe, ore, rxne, tc, txe};
            UART_MUX_BAUD: rdata = {16'd0, baud};
            UART_MUX_TDR:  rdata = {24'd0, tdr};
            UART_MUX_RDR:  rdata = {24'd0, rdr};
            default:       rdata = 32'd0;
        endcase
    end

    assign irq = (ctrl[CTRL_TXIE] && txe) || (ctrl[CTRL_RXIE] && rxne);

endmodule

// File: tb/tb_uart_regs.sv
// tb_uart_regs
// Self-checking bench for uart_regs: register reset values, BAUD clamping,
// TX waveform against an arithmetic frame model, back-to-back TX, loopback
// RX, overrun, framing error, glitch rejection and asynchronous reset.
module tb_uart_regs;
    localparam int          BIT_CLKS = 8;
    localparam int          LOG_N    = 16384;
    localparam logic [2:0]  R_CTRL = 3'd0, R_STAT = 3'd1, R_BAUD = 3'd2, R_TDR = 3'd3, R_RDR = 3'd4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we_uart = 1'b0;
    logic [2:0]  uart_reg_mux_out = 3'd0;
    logic [2:0]  rd_sel = 3'd0;
    logic        rd_en = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        tx, irq;
    logic        rx_drv = 1'b1;
    logic        loopback = 1'b0;
    logic        rx_w;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic tx_log [0:LOG_N-1];

    assign rx_w = loopback ? tx : rx_drv;

    uart_regs dut (
        .clk(clk), .rst_n(rst_n), .we_uart(we_uart),
        .uart_reg_mux_out(uart_reg_mux_out), .rd_sel(rd_sel), .rd_en(rd_en),
        .wdata(wdata), .rdata(rdata), .rx(rx_w), .tx(tx), .irq(irq)
    );

    // Clock / cycle counter / tx recorder
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;
    always @(negedge clk) if (cyc < LOG_N) tx_log[cyc] = tx;

    // Driver tasks
    task automatic bus_write(input logic [2:0] sel, input logic [31:0] d);
        @(negedge clk);
        we_uart = 1'b1; uart_reg_mux_out = sel; wdata = d;
        @(negedge clk);
        we_uart = 1'b0; wdata = 32'd0;
    endtask

    task automatic bus_read(input logic [2:0] sel, output logic [31:0] d);
        rd_sel = sel;
        #1 d = rdata;
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop_bit);
        rx_drv = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx_drv = stop_bit;
        repeat (BIT_CLKS) @(negedge clk);
        rx_drv = 1'b1;
    endtask

    // Reference model: an 8N1 line is start(0), 8 data bits LSB first,
    // stop(1), each b clocks long; after the last frame the line idles high.
    function automatic logic model_tx(input logic [7:0] f0, input logic [7:0] f1,
                                      input int nframes, input int b, input int k);
        int f;
        int slot;
        logic [7:0] byt;
        f    = k / (10 * b);
        slot = (k % (10 * b)) / b;
        if (f >= nframes) return 1'b1;
        byt = (f == 0) ? f0 : f1;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return byt[slot-1];
    endfunction

    function automatic int wave_errs(input int t0, input int len, input logic [7:0] f0,
                                     input logic [7:0] f1, input int nframes,
                                     output int first_bad);
        int n;
        n = 0;
        first_bad = -1;
        for (int k = 0; k < len; k++) begin
            if (tx_log[t0+k] !== model_tx(f0, f1, nframes, BIT_CLKS, k)) begin
                if (first_bad < 0) first_bad = k;
                n++;
            end
        end
        return n;
    endfunction

    // Tests
    task automatic test_reset();
        logic [31:0] d;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_read(R_STAT, d); checks++;
        if (d !== 32'h03) begin errors++; $display("FAIL reset_stat got %h want 00000003", d); end
        bus_read(R_BAUD, d); checks++;
        if (d !== 32'd434) begin errors++; $display("FAIL reset_baud got %0d want 434", d); end
        bus_read(R_CTRL, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h want 0", d); end
        bus_read(R_RDR, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_rdr got %h want 0", d); end
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
    endtask

    task automatic test_baud_clamp();
        logic [31:0] d;
        logic [15:0] v;
        logic [15:0] exp_v;
        for (int i = 0; i < 6; i++) begin
            v = (i % 2 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom_range(4, 65535));
            exp_v = (v < 16'd4) ? 16'd4 : v;
            bus_write(R_BAUD, {16'($urandom), v});
            bus_read(R_BAUD, d); checks++;
            if (d !== {16'd0, exp_v}) begin
                errors++; $display("FAIL baud_clamp wrote %0d got %0d want %0d", v, d, exp_v);
            end
        end
        bus_write(R_BAUD, BIT_CLKS);
    endtask

    task automatic test_tx_frame();
        logic [31:0] d;
        int t0, nbad, first;
        bus_write(R_CTRL, 32'h1);
        bus_write(R_TDR, 32'hA5);
        t0 = cyc;
        bus_read(R_STAT, d); checks++;
        if (d !== 32'h01) begin errors++; $display("FAIL tx_stat_busy got %h want 01", d); end
        repeat (79) @(negedge clk);
        bus_read(R_STAT, d); checks++;
        if (d[1] !== 1'b0) begin errors++; $display("FAIL tx_tc_early got %b want 0 at clk 79", d[1]); end
        @(negedge clk);
        bus_read(R_STAT, d); checks++;
        if (d !== 32'h03) begin errors++; $display("FAIL tx_tc_80 got %h want 03", d); end
        @(negedge clk);
        nbad = wave_errs(t0, 81, 8'hA5, 8'h00, 1, first); checks++;
        if (nbad != 0) begin
            errors++; $display("FAIL tx_wave_a5 got %0d bad cycles (first at %0d) want 0", nbad, first);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        int t0, nbad, first;
        bus_write(R_TDR, 32'h11);
        t0 = cyc;
        repeat (20) @(negedge clk);
        bus_write(R_TDR, 32'h22);
        bus_read(R_STAT, d); checks++;
        if (d !== 32'h00) begin errors++; $display("FAIL b2b_stat_full got %h want 00", d); end
        bus_write(R_TDR, 32'h33);
        bus_read(R_TDR, d); checks++;
        if (d !== 32'h22) begin errors++; $display("FAIL b2b_drop got %h want 22", d); end
        while (cyc < t0 + 182) @(negedge clk);
        nbad = wave_errs(t0, 180, 8'h11, 8'h22, 2, first); checks++;
        if (nbad != 0) begin
            errors++; $display("FAIL b2b_wave got %0d bad cycles (first at %0d) want 0", nbad, first);
        end
        bus_read(R_STAT, d); checks++;
        if (d !== 32'h03) begin errors++; $display("FAIL b2b_stat_end got %h want 03", d); end
    endtask

    task automatic test_loopback();
        logic [31:0] d;
        logic [7:0]  b;
        loopback = 1'b1;
        bus_write(R_CTRL, 32'h0B);
        for (int i = 0; i < 3; i++) begin
            b = (i == 0) ? 8'h3C : 8'($urandom);
            bus_write(R_TDR, {24'd0, b});
            repeat (100) @(negedge clk);
            bus_read(R_STAT, d); checks++;
            if (d !== 32'h07) begin errors++; $display("FAIL lb_stat byte %h got %h want 07", b, d); end
            checks++;
            if (irq !== 1'b1) begin errors++; $display("FAIL lb_irq_set got %b want 1", irq); end
            rd_en = 1'b1;
            bus_read(R_RDR, d); checks++;
            if (d !== {24'd0, b}) begin errors++; $display("FAIL lb_rdr got %h want %h", d, b); end
            @(negedge clk);
            rd_en = 1'b0;
            bus_read(R_STAT, d); checks++;
            if (d[2] !== 1'b0) begin errors++; $display("FAIL lb_rxne_clr got %b want 0", d[2]); end
            checks++;
            if (irq !== 1'b0) begin errors++; $display("FAIL lb_irq_clr got %b want 0", irq); end
        end
        loopback = 1'b0;
    endtask

    task automatic test_overrun_fe_glitch();
        logic [31:0] d;
        logic [7:0]  a, b2, c, e;
        a  = 8'($urandom);
        b2 = ~a;
        c  = 8'($urandom);
        e  = 8'($urandom);
        bus_write(R_CTRL, 32'h2);
        send_rx(a, 1'b1);
        send_rx(b2, 1'b1);
        repeat (12) @(negedge clk);
        bus_read(R_STAT, d); checks++;
        if (d !== 32'h0F) begin errors++; $display("FAIL ore_stat got %h want 0F", d); end
        bus_read(R_RDR, d); checks++;
        if (d !== {24'd0, a}) begin errors++; $display("FAIL ore_rdr got %h want %h", d, a); end
        bus_write(R_STAT, 32'h08);
        bus_read(R_STAT, d); checks++;
        if (d !== 32'h07) begin errors++; $display("FAIL ore_clear got %h want 07", d); end
        rd_en = 1'b1; rd_sel = R_RDR;
        @(negedge clk);
        rd_en = 1'b0;
        // Framing error: RXNE must stay clear and RDR keep the old byte.
        send_rx(c, 1'b0);
        repeat (12) @(negedge clk);
        bus_read(R_STAT, d); checks++;
        if (d !== 32'h13) begin errors++; $display("FAIL fe_stat got %h want 13", d); end
        bus_read(R_RDR, d); checks++;
        if (d !== {24'd0, a}) begin errors++; $display("FAIL fe_rdr got %h want %h", d, a); end
        bus_write(R_STAT, 32'h10);
        bus_read(R_STAT, d); checks++;
        if (d !== 32'h03) begin errors++; $display("FAIL fe_clear got %h want 03", d); end
        // Two-clock low glitch on an idle line.
        @(negedge clk); rx_drv = 1'b0;
        repeat (2) @(negedge clk); rx_drv = 1'b1;
        repeat (30) @(negedge clk);
        bus_read(R_STAT, d); checks++;
        if (d !== 32'h03) begin errors++; $display("FAIL glitch_stat got %h want 03", d); end
        // Receiver still frames correctly after rejecting the glitch.
        send_rx(e, 1'b1);
        repeat (12) @(negedge clk);
        bus_read(R_RDR, d); checks++;
        if (d !== {24'd0, e}) begin errors++; $display("FAIL post_glitch_rdr got %h want %h", d, e); end
    endtask

    task automatic test_reset_mid_tx();
        logic [31:0] d;
        bus_write(R_CTRL, 32'h1);
        bus_write(R_TDR, 32'hF0);
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin errors++; $display("FAIL rst_pre_tx got %b want 0", tx); end
        rst_n = 1'b0;
        #1; checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL rst_async_tx got %b want 1", tx); end
        bus_read(R_STAT, d); checks++;
        if (d !== 32'h03) begin errors++; $display("FAIL rst_stat got %h want 03", d); end
        bus_read(R_BAUD, d); checks++;
        if (d !== 32'd434) begin errors++; $display("FAIL rst_baud got %0d want 434", d); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL rst_after_tx got %b want 1", tx); end
    endtask

    initial begin
        test_reset();
        test_baud_clamp();
        test_tx_frame();
        test_back_to_back();
        test_loopback();
        test_overrun_fe_glitch();
        test_reset_mid_tx();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
